// File: rtl/mcs4_pkg.sv
// mcs4_pkg -- shared definitions for the MCS-4 style fetch sequencer.
//   phase_e      : bus phase encoding (address phases share PH_A and are
//                  told apart by a nibble counter in the sequencer)
//   OPR_*        : opcode values of the two-word instructions
//   is_two_word  : first-word decode for two-word instructions
package mcs4_pkg;

    typedef enum logic [2:0] {
        PH_A  = 3'd0,
        PH_M1 = 3'd1,
        PH_M2 = 3'd2,
        PH_X1 = 3'd3,
        PH_X2 = 3'd4,
        PH_X3 = 3'd5
    } phase_e;

    localparam logic [3:0] OPR_JCN = 4'h1;
    localparam logic [3:0] OPR_FIM = 4'h2;
    localparam logic [3:0] OPR_JUN = 4'h4;
    localparam logic [3:0] OPR_JMS = 4'h5;
    localparam logic [3:0] OPR_ISZ = 4'h7;

    // FIM shares its opcode with SRC; only the even-OPA form takes a data word.
    function automatic logic is_two_word(input logic [3:0] opr, input logic opa0);
        return (opr == OPR_JCN) || (opr == OPR_JUN) || (opr == OPR_JMS) ||
               (opr == OPR_ISZ) || ((opr == OPR_FIM) && !opa0);
    endfunction

endpackage

// File: rtl/mcs4_seq_if.sv
// mcs4_seq_if -- bus / control bundle of the fetch sequencer.
//   master : bus phase clock, data in, jump/call/return requests (driver side)
//   slave  : the sequencer; drives address nibbles, SYNC, CM-ROM and the
//            decoded instruction outputs
interface mcs4_seq_if #(
    parameter int DATA_W   = 4,
    parameter int ADDR_NIB = 3
);
    localparam int PCW = DATA_W * ADDR_NIB;

    logic                  PHI2_i;
    logic [DATA_W-1:0]     D_i;
    logic [DATA_W-1:0]     D_o;
    logic                  D_oe_o;
    logic                  SYNC_o;
    logic                  CM_ROM_o;
    logic                  jmp_i;
    logic                  call_i;
    logic                  ret_i;
    logic [PCW-1:0]        jmp_addr_i;
    logic                  instr_valid_o;
    logic [DATA_W-1:0]     opr_o;
    logic [DATA_W-1:0]     opa_o;
    logic [2*DATA_W-1:0]   word2_o;
    logic                  two_word_o;

    modport master (
        output PHI2_i, D_i, jmp_i, call_i, ret_i, jmp_addr_i,
        input  D_o, D_oe_o, SYNC_o, CM_ROM_o, instr_valid_o, opr_o, opa_o,
               word2_o, two_word_o
    );

    modport slave (
        input  PHI2_i, D_i, jmp_i, call_i, ret_i, jmp_addr_i,
        output D_o, D_oe_o, SYNC_o, CM_ROM_o, instr_valid_o, opr_o, opa_o,
               word2_o, two_word_o
    );
endinterface

// File: rtl/mcs4_edge_det.sv
// mcs4_edge_det -- samples the bus phase clock and flags its rising edge.
//   i_clk   : design clock
//   i_rst_n : synchronous active-low reset
//   i_phi2  : bus phase clock (asynchronous to i_clk, slow)
//   o_rise  : high for one clk after the first sample of 1 following a 0
module mcs4_edge_det (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_phi2,
    output logic o_rise
);
    logic r_phi;
    logic r_phi_d;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_phi   <= 1'b0;
            r_phi_d <= 1'b0;
        end else begin
            r_phi   <= i_phi2;
            r_phi_d <= r_phi;
        end
    end

    // A held-high phase clock yields exactly one pulse.
    assign o_rise = r_phi & ~r_phi_d;
endmodule

// File: rtl/mcs4_seq.sv
// mcs4_seq -- MCS-4 style instruction fetch sequencer.
//   clk_i     : design clock, all state on its rising edge
//   RESET_N_i : synchronous active-low reset
//   bus       : mcs4_seq_if.slave -- phase clock, data bus, SYNC/CM-ROM,
//               jump/call/return requests, decoded instruction outputs
// One instruction cycle is A1..A<ADDR_NIB>, M1, M2, X1, X2, X3; each step is
// one PHI2 rising edge. The PC is driven out LSB nibble first in the A phases,
// the opcode is read in M1/M2, and PC changes (increment, jump, call, return)
// are applied around the X phases.
module mcs4_seq
    import mcs4_pkg::*;
#(
    parameter int DATA_W      = 4,
    parameter int ADDR_NIB    = 3,
    parameter int STACK_DEPTH = 3
) (
    input  logic      clk_i,
    input  logic      RESET_N_i,
    mcs4_seq_if.slave bus
);
    localparam int PCW = DATA_W * ADDR_NIB;
    localparam int SPW = $clog2(STACK_DEPTH);
    localparam int AW  = (ADDR_NIB > 1) ? $clog2(ADDR_NIB) : 1;

    logic                 w_rise;
    phase_e               r_phase;
    logic [AW-1:0]        r_anib;
    logic [PCW-1:0]       r_pc;
    logic [PCW-1:0]       r_stk [STACK_DEPTH];
    logic [SPW-1:0]       r_sp;
    logic                 r_ld;
    logic [PCW-1:0]       r_ld_addr;
    logic [DATA_W-1:0]    r_opr_cap;
    logic                 r_second;
    logic [DATA_W-1:0]    r_first_opr;
    logic [DATA_W-1:0]    r_first_opa;
    logic [DATA_W-1:0]    r_d_o;
    logic                 r_d_oe;
    logic                 r_sync;
    logic                 r_cm;
    logic                 r_vld;
    logic [DATA_W-1:0]    r_opr;
    logic [DATA_W-1:0]    r_opa;
    logic [2*DATA_W-1:0]  r_word2;
    logic                 r_two;

    mcs4_edge_det u_edge (
        .i_clk   (clk_i),
        .i_rst_n (RESET_N_i),
        .i_phi2  (bus.PHI2_i),
        .o_rise  (w_rise)
    );

    logic [PCW-1:0]      w_pc_a1;
    logic [PCW-1:0]      w_pc_inc;
    logic [SPW-1:0]      w_sp_inc;
    logic [SPW-1:0]      w_sp_dec;
    logic [AW-1:0]       w_nib_nxt;
    logic                w_last_a;
    logic [2*DATA_W-1:0] w_word;
    logic                w_two;

    // A pending load replaces the PC at A1 entry, overriding the X1 increment.
    assign w_pc_a1   = r_ld ? r_ld_addr : r_pc;
    assign w_pc_inc  = r_pc + 1'b1;
    assign w_sp_inc  = (r_sp == SPW'(STACK_DEPTH - 1)) ? '0 : r_sp + 1'b1;
    assign w_sp_dec  = (r_sp == '0) ? SPW'(STACK_DEPTH - 1) : r_sp - 1'b1;
    assign w_nib_nxt = r_anib + 1'b1;
    assign w_last_a  = (r_anib == AW'(ADDR_NIB - 1));
    assign w_word    = {r_opr_cap, bus.D_i};
    assign w_two     = is_two_word(r_opr_cap[3:0], bus.D_i[0]);

    always_ff @(posedge clk_i) begin
        if (!RESET_N_i) begin
            r_phase     <= PH_X3;
            r_anib      <= '0;
            r_pc        <= '0;
            r_sp        <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) r_stk[i] <= '0;
            r_ld        <= 1'b0;
            r_ld_addr   <= '0;
            r_opr_cap   <= '0;
            r_second    <= 1'b0;
            r_first_opr <= '0;
            r_first_opa <= '0;
            r_d_o       <= '0;
            r_d_oe      <= 1'b0;
            r_sync      <= 1'b1;
            r_cm        <= 1'b0;
            r_vld       <= 1'b0;
            r_opr       <= '0;
            r_opa       <= '0;
            r_word2     <= '0;
            r_two       <= 1'b0;
        end else begin
            r_vld <= 1'b0;
            if (w_rise) begin
                unique case (r_phase)
                    PH_X3: begin
                        r_phase <= PH_A;
                        r_anib  <= '0;
                        r_pc    <= w_pc_a1;
                        r_ld    <= 1'b0;
                        r_d_o   <= w_pc_a1[DATA_W-1:0];
                        r_d_oe  <= 1'b1;
                        r_sync  <= 1'b0;
                        r_cm    <= (ADDR_NIB == 1);
                    end
                    PH_A: begin
                        if (w_last_a) begin
                            r_phase <= PH_M1;
                            r_d_o   <= '0;
                            r_d_oe  <= 1'b0;
                            r_cm    <= 1'b0;
                        end else begin
                            r_anib <= w_nib_nxt;
                            r_d_o  <= r_pc[w_nib_nxt*DATA_W +: DATA_W];
                            r_cm   <= (w_nib_nxt == AW'(ADDR_NIB - 1));
                        end
                    end
                    PH_M1: begin
                        r_phase   <= PH_M2;
                        r_opr_cap <= bus.D_i;
                    end
                    PH_M2: begin
                        r_phase <= PH_X1;
                        r_pc    <= w_pc_inc;
                        // A second word never starts a new two-word instruction.
                        if (r_second) begin
                            r_vld    <= 1'b1;
                            r_opr    <= r_first_opr;
                            r_opa    <= r_first_opa;
                            r_word2  <= w_word;
                            r_two    <= 1'b1;
                            r_second <= 1'b0;
                        end else if (w_two) begin
                            r_second    <= 1'b1;
                            r_first_opr <= r_opr_cap;
                            r_first_opa <= bus.D_i;
                        end else begin
                            r_vld   <= 1'b1;
                            r_opr   <= r_opr_cap;
                            r_opa   <= bus.D_i;
                            r_word2 <= '0;
                            r_two   <= 1'b0;
                        end
                    end
                    PH_X1: r_phase <= PH_X2;
                    PH_X2: begin
                        r_phase <= PH_X3;
                        r_sync  <= 1'b1;
                        // Return beats call beats jump; r_pc already holds the
                        // incremented value, i.e. the return address.
                        if (bus.ret_i) begin
                            r_ld      <= 1'b1;
                            r_ld_addr <= r_stk[w_sp_dec];
                            r_sp      <= w_sp_dec;
                        end else if (bus.call_i) begin
                            r_stk[r_sp] <= r_pc;
                            r_sp        <= w_sp_inc;
                            r_ld        <= 1'b1;
                            r_ld_addr   <= bus.jmp_addr_i;
                        end else if (bus.jmp_i) begin
                            r_ld      <= 1'b1;
                            r_ld_addr <= bus.jmp_addr_i;
                        end
                    end
                    default: r_phase <= PH_X3;
                endcase
            end
        end
    end

    assign bus.D_o           = r_d_o;
    assign bus.D_oe_o        = r_d_oe;
    assign bus.SYNC_o        = r_sync;
    assign bus.CM_ROM_o      = r_cm;
    assign bus.instr_valid_o = r_vld;
    assign bus.opr_o         = r_opr;
    assign bus.opa_o         = r_opa;
    assign bus.word2_o       = r_word2;
    assign bus.two_word_o    = r_two;
endmodule

// File: tb/tb_mcs4_seq.sv
// tb_mcs4_seq -- scoreboard bench for mcs4_seq. The driver issues whole
// instruction cycles and pushes the expected fetch address and decoded
// instruction into queues; the monitor pops and compares as the DUT
// presents A-phase nibbles and instr_valid_o pulses.
module tb_mcs4_seq;
    localparam int DEPTH = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mcs4_seq_if #(.DATA_W(4), .ADDR_NIB(3)) bus ();

    mcs4_seq #(.DATA_W(4), .ADDR_NIB(3), .STACK_DEPTH(DEPTH)) dut (
        .clk_i     (clk),
        .RESET_N_i (rst_n),
        .bus       (bus)
    );

    typedef struct {
        logic [3:0] opr;
        logic [3:0] opa;
        logic [7:0] w2;
        logic       two;
    } inst_t;

    inst_t       iq[$];
    logic [11:0] aq[$];
    int          errs = 0;
    int          chks = 0;
    logic        done = 1'b0;

    // Reference model: PC, circular return stack, pending first word.
    logic [11:0] m_pc;
    logic [11:0] m_stk[DEPTH];
    int          m_sp;
    logic        m_pend;
    logic [7:0]  m_first;

    task automatic model_reset();
        m_pc = '0; m_sp = 0; m_pend = 1'b0; m_first = '0;
        for (int i = 0; i < DEPTH; i++) m_stk[i] = '0;
    endtask

    // One PHI2 period: high for two clks, low for two clks.
    task automatic step();
        bus.PHI2_i = 1'b1;
        @(posedge clk); @(posedge clk); #2;
        bus.PHI2_i = 1'b0;
        @(posedge clk); @(posedge clk); #2;
    endtask

    task automatic do_reset();
        bus.PHI2_i = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        model_reset();
    endtask

    // Full instruction cycle fetching word w; requests held into X3 entry.
    // abort stops right after M2 entry (for the mid-cycle reset case).
    task automatic cycle(input logic [7:0] w, input bit j, input bit c,
                         input bit r, input logic [11:0] a, input bit abort);
        logic [3:0] hi, lo;
        hi = w[7:4];
        lo = w[3:0];
        aq.push_back(m_pc);
        repeat (4) step();            // A1, A2, A3, M1
        bus.D_i = hi; step();         // M2
        if (abort) return;
        m_pc = m_pc + 12'd1;
        if (m_pend) begin
            iq.push_back('{m_first[7:4], m_first[3:0], w, 1'b1});
            m_pend = 1'b0;
        end else if ((hi inside {4'h1, 4'h4, 4'h5, 4'h7}) || (hi == 4'h2 && !lo[0])) begin
            m_pend = 1'b1;
            m_first = w;
        end else begin
            iq.push_back('{hi, lo, 8'h00, 1'b0});
        end
        bus.D_i = lo; step();         // X1
        step();                       // X2
        bus.jmp_i = j; bus.call_i = c; bus.ret_i = r; bus.jmp_addr_i = a;
        step();                       // X3
        bus.jmp_i = 1'b0; bus.call_i = 1'b0; bus.ret_i = 1'b0;
        if (r) begin
            m_sp = (m_sp + DEPTH - 1) % DEPTH;
            m_pc = m_stk[m_sp];
        end else if (c) begin
            m_stk[m_sp] = m_pc;
            m_sp = (m_sp + 1) % DEPTH;
            m_pc = a;
        end else if (j) begin
            m_pc = a;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor
    int          oe_cnt = 0;
    int          sync_cnt = -1;
    bit          rst_seen = 0;
    logic        prev_vld = 1'b0;
    logic [11:0] addr_got;
    logic [11:0] addr_exp;
    inst_t       ie;

    always @(negedge clk) begin
        if (!rst_n) begin
            if (rst_seen) begin
                chk("rst_sync", bus.SYNC_o, 1);
                chk("rst_oe", bus.D_oe_o, 0);
                chk("rst_vld", bus.instr_valid_o, 0);
                chk("rst_cm", bus.CM_ROM_o, 0);
                chk("rst_outs", {bus.D_o, bus.opr_o, bus.opa_o, bus.word2_o, bus.two_word_o}, 0);
            end
            rst_seen = 1;
            oe_cnt   = 0;
            sync_cnt = -1;
            prev_vld = 1'b0;
        end else begin
            rst_seen = 0;
            if (bus.D_oe_o) begin
                if (oe_cnt % 4 == 0 && oe_cnt < 12) begin
                    addr_got[(oe_cnt/4)*4 +: 4] = bus.D_o;
                    chk("cm_rom", bus.CM_ROM_o, (oe_cnt == 8) ? 1 : 0);
                    if (oe_cnt == 8) begin
                        if (aq.size() == 0) chk("addr_unexpected", 1, 0);
                        else begin
                            addr_exp = aq.pop_front();
                            chk("addr", addr_got, addr_exp);
                        end
                    end
                end
                oe_cnt++;
            end else begin
                if (oe_cnt != 0) chk("oe_len", oe_cnt, 12);
                oe_cnt = 0;
            end
            if (bus.SYNC_o) begin
                if (sync_cnt >= 0) sync_cnt++;
            end else begin
                if (sync_cnt > 0) chk("sync_len", sync_cnt, 4);
                sync_cnt = 0;
            end
            if (bus.instr_valid_o) begin
                chk("vld_width", prev_vld, 0);
                chk("x1_sync_oe", {bus.SYNC_o, bus.D_oe_o}, 0);
                if (iq.size() == 0) chk("instr_unexpected", 1, 0);
                else begin
                    ie = iq.pop_front();
                    chk("opr", bus.opr_o, ie.opr);
                    chk("opa", bus.opa_o, ie.opa);
                    chk("word2", bus.word2_o, ie.w2);
                    chk("two_word", bus.two_word_o, ie.two);
                end
            end
            prev_vld = bus.instr_valid_o;
        end
        if (done) begin
            chk("iq_empty", iq.size(), 0);
            chk("aq_empty", aq.size(), 0);
            $display("Result: errors=%0d of %0d checks", errs, chks);
            $finish;
        end
    end

    initial begin
        bus.PHI2_i = 1'b0; bus.D_i = '0;
        bus.jmp_i = 1'b0; bus.call_i = 1'b0; bus.ret_i = 1'b0; bus.jmp_addr_i = '0;
        model_reset();
        @(posedge clk); #2;
        do_reset();
        cycle(8'hD2, 0, 0, 0, 12'h000, 0);          // single word
        cycle(8'h41, 0, 0, 0, 12'h000, 0);          // two-word pair
        cycle(8'h23, 0, 0, 0, 12'h000, 0);
        cycle(8'hD0, 1, 0, 0, 12'h005, 0);          // jump to 5
        cycle(8'hD0, 0, 1, 0, 12'hABC, 0);          // call at PC 5
        cycle(8'hD0, 0, 0, 1, 12'h000, 0);          // return to 6
        cycle(8'hD0, 0, 0, 0, 12'h000, 0);
        for (int i = 0; i < 4; i++) cycle(8'hD0, 0, 1, 0, 12'($urandom), 0);
        for (int i = 0; i < 4; i++) cycle(8'hD0, 0, 0, 1, 12'h000, 0);
        cycle(8'hD0, 1, 0, 0, 12'hFFF, 0);
        cycle(8'hD0, 1, 0, 1, 12'h123, 0);          // PC wraps, ret beats jmp
        cycle(8'hD0, 0, 0, 0, 12'h000, 0);
        for (int i = 0; i < 40; i++)
            cycle(8'($urandom), ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 5) == 0), 12'($urandom), 0);
        cycle(8'h14, 0, 0, 0, 12'h000, 0);          // first word of a pair
        cycle(8'h10, 0, 0, 0, 12'h000, 1);          // reset during M2
        do_reset();
        cycle(8'h10, 0, 0, 0, 12'h000, 0);          // fresh first word at PC 0
        cycle(8'h55, 0, 0, 0, 12'h000, 0);
        cycle(8'hD2, 0, 0, 0, 12'h000, 0);
        repeat (8) @(posedge clk);
        done = 1'b1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not complete, errors=%0d checks=%0d", errs, chks);
        $fatal(1);
    end
endmodule

// File: doc/mcs4_seq.md
MCS4_SEQ -- requirements
Module: mcs4_seq

Interface
REQ-001 SHALL have parameter DATA_W, default 4: data bus and nibble width in bits.
REQ-002 SHALL have parameter ADDR_NIB, default 3: address nibbles per cycle; PC width = DATA_W*ADDR_NIB.
REQ-003 SHALL have parameter STACK_DEPTH, default 3: return-stack entries, 2..8.
REQ-004 SHALL use one clock, clk_i, and a synchronous active-low reset, RESET_N_i.
REQ-005 clk_i  in  1  design clock; all state updates on its rising edge.
REQ-006 RESET_N_i  in  1  synchronous active-low reset.
REQ-007 PHI2_i  in  1  bus phase clock; each rising edge, sampled on clk_i, advances one phase.
REQ-008 D_i  in  DATA_W  data bus input.
REQ-009 D_o  out  DATA_W  data bus output; D_oe_o  out  1  bus drive enable.
REQ-010 SYNC_o  out  1  high for the whole X3 phase.
REQ-011 CM_ROM_o  out  1  high for the whole last address phase.
REQ-012 jmp_i  in  1  and jmp_addr_i  in  PC width: load PC.
REQ-013 call_i  in  1: push the current PC, then load jmp_addr_i.
REQ-014 ret_i  in  1: pop the PC from the stack.
REQ-015 instr_valid_o  out  1  one-clk pulse; opr_o, opa_o  out  DATA_W each; word2_o  out  2*DATA_W; two_word_o  out  1.

Function
REQ-016 The phase sequence SHALL be A1..A<ADDR_NIB>, M1, M2, X1, X2, X3, then back to A1; one step per detected PHI2_i rising edge.
REQ-017 PHI2 edge detection SHALL register PHI2_i; the phase changes on the clk after the first sample of PHI2_i=1 following a 0, and never on a held-high PHI2_i.
REQ-018 In phase Ak, D_o SHALL equal PC nibble k-1 (A1 = least significant) and D_oe_o SHALL be 1; D_oe_o SHALL be 0 in all other phases.
REQ-019 D_i SHALL be captured into the high opcode nibble on exit from M1 and into the low opcode nibble on exit from M2.
REQ-020 The PC SHALL increment by 1, modulo 2^(PC width), on entry to X1, every cycle.
REQ-021 A fetched word SHALL be the first word of a two-word instruction when: OPR = 1, 4, 5 or 7; or OPR = 2 with OPA[0] = 0. This applies only when the word is not itself a second word.
REQ-022 When the first word is detected, the block SHALL hold it and produce no pulse for that cycle; the next cycle's word becomes word2_o.
REQ-023 instr_valid_o SHALL pulse for one clk on entry to X1 of each cycle that completes an instruction. At that point opr_o/opa_o are the first word, two_word_o is the two-word flag, and word2_o is 0 for single-word instructions.
REQ-024 Outputs opr_o, opa_o, word2_o and two_word_o SHALL hold their values until the next pulse.
REQ-025 jmp_i, call_i and ret_i SHALL be sampled on the clk of entry to X3. The resulting PC load takes effect on entry to A1 and overrides the increment.
REQ-026 Simultaneous requests SHALL resolve with priority ret_i > call_i > jmp_i; the lower-priority requests are ignored.
REQ-027 The stack SHALL be circular with pointer modulo STACK_DEPTH.
REQ-028 A push into a full stack SHALL silently overwrite the oldest entry; a pop from an empty stack SHALL return the wrapped entry without error.
REQ-029 A push SHALL store the PC value already incremented in X1, i.e. the return address.

Reset
REQ-030 While RESET_N_i=0 on a clk edge, the block SHALL set: phase = X3; PC = 0; stack pointer = 0; all stack entries = 0; held and pending requests cleared; all outputs 0 except SYNC_o = 1.
REQ-031 Reset mid-cycle SHALL discard any partial opcode, any pending two-word state and any pending jump.
REQ-032 After RESET_N_i returns high, the first PHI2 edge SHALL enter A1 with PC = 0.

Structure
REQ-033 Shared package mcs4_pkg SHALL hold the phase enumeration, opcode constants (JCN, FIM, JUN, JMS, ISZ) and the two-word decode function.
REQ-034 PHI2 synchronisation and edge detection SHALL be a sub-module mcs4_edge_det.
REQ-035 Phase decode, PC, stack and opcode capture SHALL reside in mcs4_seq.

Verification
REQ-036 Reset, then 8 PHI2 edges with D_i=4'hD then 4'h2 -> D_o 0,0,0 during A1..A3; CM_ROM_o high in A3; instr_valid_o with opr_o=D, opa_o=2, two_word_o=0; SYNC_o high in X3.
REQ-037 Feed 4'h4,4'h1 then 4'h2,4'h3 -> a single pulse after the second cycle with opr_o=4, opa_o=1, word2_o=8'h23, two_word_o=1; PC = 2.
REQ-038 call_i with jmp_addr_i=12'hABC at PC=5 -> next A-phases drive C,B,A; a later ret_i -> A-phases drive PC 6.
REQ-039 Four calls with STACK_DEPTH=3 then four rets -> the return addresses wrap as circular overwrite dictates, with no X/hang.
REQ-040 PC=12'hFFF -> increments to 12'h000; ret_i and jmp_i asserted together -> ret wins.
REQ-041 RESET_N_i low during M2 of a two-word first word -> no pulse; the next fetch is treated as a first word at PC 0.
